// File: rtl/memory_pkg.sv
// rtl/memory_pkg.sv - shared memory sizing constants and data memory FSM state type
package memory_pkg;

  localparam int DATA_MEM_SIZE_BYTES = 4096;
  localparam int DATA_MEM_SIZE_WORDS = DATA_MEM_SIZE_BYTES / 4;
  localparam int DATA_MEM_LATENCY    = 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } data_mem_state_t;

endpackage

// File: rtl/data_mem_bank.sv
// rtl/data_mem_bank.sv - word array with byte-masked synchronous write and synchronous read
module data_mem_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int WORDS      = 1024,
  localparam int BE_W      = DATA_WIDTH / 8,
  localparam int IDX_W     = $clog2(WORDS)
) (
  input  logic                  clk_i,
  input  logic                  we,
  input  logic [BE_W-1:0]       be,
  input  logic [IDX_W-1:0]      idx,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] r_mem [WORDS];

  always_ff @(posedge clk_i) begin
    if (we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (be[b]) begin
          r_mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
    rdata <= r_mem[idx];
  end

endmodule

// File: rtl/data_mem_ws.sv
// rtl/data_mem_ws.sv - data memory with configurable wait states, byte enables and range error
module data_mem_ws
  import memory_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SIZE_BYTES = memory_pkg::DATA_MEM_SIZE_BYTES,
  parameter int LATENCY    = memory_pkg::DATA_MEM_LATENCY,
  localparam int BE_W      = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  mem_req_i,
  input  logic                  write_enable_i,
  input  logic [BE_W-1:0]       byte_enable_i,
  input  logic [31:0]           addr_i,
  input  logic [DATA_WIDTH-1:0] write_data_i,
  output logic [DATA_WIDTH-1:0] read_data_o,
  output logic                  ready_o,
  output logic                  err_o
);

  localparam int WORDS = SIZE_BYTES / BE_W;
  localparam int BO    = $clog2(BE_W);
  localparam int IDX_W = $clog2(WORDS);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  data_mem_state_t       r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [31:0]           r_addr;
  logic                  r_we;
  logic [BE_W-1:0]       r_be;
  logic [DATA_WIDTH-1:0] r_wdata;

  logic                  w_oor;
  logic                  w_commit;
  logic                  w_bank_we;
  logic [IDX_W-1:0]      w_bank_idx;
  logic [DATA_WIDTH-1:0] w_bank_rdata;

  assign w_oor     = (r_addr >= 32'(SIZE_BYTES));
  assign w_commit  = (r_state == BUSY) && (r_cnt == '0);
  assign w_bank_we = w_commit && r_we && !w_oor;

  // Reading from the live address in IDLE makes the bank output valid one edge after
  // accept, which is early enough for LATENCY = 1; in BUSY it tracks the captured word.
  assign w_bank_idx = (r_state == IDLE) ? addr_i[BO +: IDX_W] : r_addr[BO +: IDX_W];

  data_mem_bank #(
    .DATA_WIDTH(DATA_WIDTH),
    .WORDS     (WORDS)
  ) u_bank (
    .clk_i(clk_i),
    .we   (w_bank_we),
    .be   (r_be),
    .idx  (w_bank_idx),
    .wdata(r_wdata),
    .rdata(w_bank_rdata)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_we        <= 1'b0;
      r_be        <= '0;
      r_wdata     <= '0;
      read_data_o <= '0;
      ready_o     <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      ready_o <= 1'b0;
      err_o   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (mem_req_i) begin
            r_addr  <= addr_i;
            r_we    <= write_enable_i;
            r_be    <= byte_enable_i;
            r_wdata <= write_data_i;
            r_cnt   <= CNT_W'(LATENCY - 1);
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            ready_o <= 1'b1;
            err_o   <= w_oor;
            if (!r_we) begin
              read_data_o <= w_oor ? '0 : w_bank_rdata;
            end
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
